// File: rtl/lsu_mem_master.sv
// Core-side initiator for the word-wide req/gnt/rvalid data bus: one load/store per command,
// sub-word loads are extracted and extended, sub-word stores are done as read-modify-write.
module lsu_mem_master #(
    parameter int unsigned RV_TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic        data_req,
    output logic [31:0] data_adr,
    output logic [31:0] data_write,
    output logic        data_write_enable,
    input  logic        data_gnt,
    input  logic        data_rvalid,
    input  logic [31:0] data_read
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

    localparam int CW = (RV_TIMEOUT > 1) ? $clog2(RV_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((RV_TIMEOUT == 0) ? 0 : RV_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (RV_TIMEOUT != 0);

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic        cmd_we;
    logic [1:0]  cmd_size;
    logic        cmd_uns;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    // Result waiting in DONE; it is published on the lsu_* outputs at the next edge.
    logic        res_err, res_err_n;
    logic [31:0] res_data, res_data_n;

    logic        req_n, we_n, done_n, err_n;
    logic [31:0] adr_n, write_n, rdata_n;

    logic        bad_cmd, timed_out;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val, merged;

    assign lsu_ready_o = (state == IDLE);

    assign bad_cmd = (lsu_size_i == 2'b11)
                   || ((lsu_size_i == 2'b01) && lsu_addr_i[0])
                   || ((lsu_size_i == 2'b10) && (lsu_addr_i[1:0] != 2'b00));

    assign timed_out = TIMEOUT_EN && (cnt == CNT_LAST);

    always_comb begin
        rd_byte = data_read[{cmd_addr[1:0], 3'b000} +: 8];
        rd_half = data_read[{cmd_addr[1], 4'b0000} +: 16];
        case (cmd_size)
            2'b00:   load_val = {{24{rd_byte[7] & ~cmd_uns}}, rd_byte};
            2'b01:   load_val = {{16{rd_half[15] & ~cmd_uns}}, rd_half};
            default: load_val = data_read;
        endcase
        merged = data_read;
        if (cmd_size == 2'b00) begin
            merged[{cmd_addr[1:0], 3'b000} +: 8] = cmd_wdata[7:0];
        end else begin
            merged[{cmd_addr[1], 4'b0000} +: 16] = cmd_wdata[15:0];
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        res_err_n  = res_err;
        res_data_n = res_data;
        req_n      = 1'b0;
        adr_n      = data_adr;
        write_n    = data_write;
        we_n       = data_write_enable;
        done_n     = 1'b0;
        err_n      = 1'b0;
        rdata_n    = lsu_rdata_o;

        case (state)
            IDLE: begin
                if (lsu_valid_i) begin
                    res_err_n  = 1'b0;
                    res_data_n = '0;
                    if (bad_cmd) begin
                        res_err_n = 1'b1;
                        state_n   = DONE;
                    end else begin
                        req_n = 1'b1;
                        adr_n = {lsu_addr_i[31:2], 2'b00};
                        if (lsu_we_i && (lsu_size_i == 2'b10)) begin
                            write_n = lsu_wdata_i;
                            we_n    = 1'b1;
                            state_n = WR_REQ;
                        end else begin
                            we_n    = 1'b0;
                            state_n = RD_REQ;
                        end
                    end
                end
            end

            RD_REQ, WR_REQ: begin
                // Request is held until granted; no timeout while waiting for a grant.
                req_n = 1'b1;
                if (data_gnt) begin
                    req_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = (state == RD_REQ) ? RD_WAIT : WR_WAIT;
                end
            end

            RD_WAIT, WR_WAIT: begin
                if (data_rvalid) begin
                    if (state == WR_WAIT) begin
                        state_n = DONE;
                    end else if (cmd_we) begin
                        write_n = merged;
                        we_n    = 1'b1;
                        req_n   = 1'b1;
                        state_n = WR_REQ;
                    end else begin
                        res_data_n = load_val;
                        state_n    = DONE;
                    end
                end else if (timed_out) begin
                    res_err_n  = 1'b1;
                    res_data_n = '0;
                    state_n    = DONE;
                end else if (TIMEOUT_EN) begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DONE: begin
                done_n  = 1'b1;
                err_n   = res_err;
                rdata_n = res_data;
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            cnt               <= '0;
            cmd_we            <= 1'b0;
            cmd_size          <= 2'b00;
            cmd_uns           <= 1'b0;
            cmd_addr          <= '0;
            cmd_wdata         <= '0;
            res_err           <= 1'b0;
            res_data          <= '0;
            data_req          <= 1'b0;
            data_adr          <= '0;
            data_write        <= '0;
            data_write_enable <= 1'b0;
            lsu_done_o        <= 1'b0;
            lsu_err_o         <= 1'b0;
            lsu_rdata_o       <= '0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            res_err           <= res_err_n;
            res_data          <= res_data_n;
            data_req          <= req_n;
            data_adr          <= adr_n;
            data_write        <= write_n;
            data_write_enable <= we_n;
            lsu_done_o        <= done_n;
            lsu_err_o         <= err_n;
            lsu_rdata_o       <= rdata_n;
            if ((state == IDLE) && lsu_valid_i) begin
                cmd_we    <= lsu_we_i;
                cmd_size  <= lsu_size_i;
                cmd_uns   <= lsu_unsigned_i;
                cmd_addr  <= lsu_addr_i;
                cmd_wdata <= lsu_wdata_i;
            end
        end
    end

endmodule
